// File: rtl/sync_timing_decoder_pkg.sv
// Shared VGA timing package: generator timing constants, decoder state encoding
// and counter-width helpers.
package sync_timing_decoder_pkg;

    localparam int unsigned VGA_TOTAL_COLUMNS  = 800;
    localparam int unsigned VGA_ACTIVE_COLUMNS = 640;
    localparam int unsigned VGA_TOTAL_ROWS     = 525;
    localparam int unsigned VGA_ACTIVE_ROWS    = 480;
    localparam int unsigned VGA_LOCK_FRAMES    = 2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } sync_state_e;

    // Bits needed to index 0..n-1 (never less than one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold the values 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return idx_width(n + 1);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Active-low sync edge detector: pulses when the previous sample was inactive (1)
// and the current sample is active (0).
module sync_edge_detect (
    input  logic sync_q_i,
    input  logic sync_i,
    output logic edge_o
);

    always_comb begin
        edge_o = sync_q_i & ~sync_i;
    end

endmodule

// File: rtl/sync_timing_decoder.sv
// Receive-side VGA timing decoder: recovers pixel coordinates from an hsync/vsync/
// video-enable stream, checks line and frame geometry, reports lock and violations.
module sync_timing_decoder
    import sync_timing_decoder_pkg::*;
#(
    parameter int unsigned TOTAL_COLUMNS  = VGA_TOTAL_COLUMNS,
    parameter int unsigned TOTAL_ROWS     = VGA_TOTAL_ROWS,
    parameter int unsigned ACTIVE_COLUMNS = VGA_ACTIVE_COLUMNS,
    parameter int unsigned ACTIVE_ROWS    = VGA_ACTIVE_ROWS,
    parameter int unsigned LOCK_FRAMES    = VGA_LOCK_FRAMES
) (
    input  logic                                            clk_i,
    input  logic                                            reset_ni,
    input  logic                                            hsync_i,
    input  logic                                            vsync_i,
    input  logic                                            video_en_i,
    output logic                                            pixel_valid_o,
    output logic [$clog2(ACTIVE_COLUMNS)-1:0]               x_o,
    output logic [$clog2(ACTIVE_ROWS)-1:0]                  y_o,
    output logic [$clog2(ACTIVE_COLUMNS*ACTIVE_ROWS)-1:0]   pixel_o,
    output logic                                            frame_start_o,
    output logic                                            locked_o,
    output logic                                            error_o
);

    localparam int unsigned HW  = $clog2(TOTAL_COLUMNS + 1);
    localparam int unsigned AW  = cnt_width(ACTIVE_COLUMNS + 1);
    localparam int unsigned VW  = cnt_width(TOTAL_ROWS + 1);
    localparam int unsigned ALW = cnt_width(ACTIVE_ROWS + 1);
    localparam int unsigned CW  = cnt_width(LOCK_FRAMES);
    localparam int unsigned XW  = $clog2(ACTIVE_COLUMNS);
    localparam int unsigned YW  = $clog2(ACTIVE_ROWS);
    localparam int unsigned PW  = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS);

    localparam logic [HW-1:0]  H_LAST     = HW'(TOTAL_COLUMNS - 1);
    localparam logic [AW-1:0]  A_LINE     = AW'(ACTIVE_COLUMNS);
    localparam logic [VW-1:0]  V_FRAME    = VW'(TOTAL_ROWS);
    localparam logic [ALW-1:0] AL_FRAME   = ALW'(ACTIVE_ROWS);
    localparam logic [CW-1:0]  CLEAN_LAST = CW'(LOCK_FRAMES - 1);
    localparam logic [XW-1:0]  X_LAST     = XW'(ACTIVE_COLUMNS - 1);
    localparam logic [YW-1:0]  Y_LAST     = YW'(ACTIVE_ROWS - 1);
    localparam logic [PW-1:0]  P_LAST     = PW'(ACTIVE_COLUMNS * ACTIVE_ROWS - 1);

    logic hs_q, vs_q, ven_q;
    logic h_edge, v_edge;

    logic [HW-1:0]  h_cnt_q, h_cnt_d;
    logic [AW-1:0]  a_cnt_q, a_cnt_d;
    logic [VW-1:0]  v_cnt_q, v_cnt_d, v_cnt_line;
    logic [ALW-1:0] al_cnt_q, al_cnt_d, al_cnt_line;
    logic           h_viol, v_viol, viol;

    logic [XW-1:0]  x_cnt_q, x_cnt_d;
    logic [YW-1:0]  y_cnt_q, y_cnt_d;
    logic [PW-1:0]  pix_cnt_q, pix_cnt_d;

    sync_state_e    state_q, state_d;
    logic [CW-1:0]  clean_q, clean_d;

    logic           valid_d;
    logic           valid_q, fs_q, err_q;
    logic [XW-1:0]  x_q;
    logic [YW-1:0]  y_q;
    logic [PW-1:0]  pix_q;

    sync_edge_detect u_hsync_edge (
        .sync_q_i (hs_q),
        .sync_i   (hsync_i),
        .edge_o   (h_edge)
    );

    sync_edge_detect u_vsync_edge (
        .sync_q_i (vs_q),
        .sync_i   (vsync_i),
        .edge_o   (v_edge)
    );

    // Line/frame geometry; a coincident H edge is folded into the ending frame
    // (v_cnt_line/al_cnt_line) before the V-edge check sees it.
    always_comb begin
        h_cnt_d     = h_cnt_q;
        a_cnt_d     = a_cnt_q;
        v_cnt_line  = v_cnt_q;
        al_cnt_line = al_cnt_q;
        h_viol      = 1'b0;
        v_viol      = 1'b0;
        if (h_edge) begin
            h_viol  = (h_cnt_q != H_LAST) || ((a_cnt_q != '0) && (a_cnt_q != A_LINE));
            h_cnt_d = '0;
            a_cnt_d = video_en_i ? AW'(1) : '0;
            if (v_cnt_q != '1) begin
                v_cnt_line = v_cnt_q + 1'b1;
            end
            if ((a_cnt_q != '0) && (al_cnt_q != '1)) begin
                al_cnt_line = al_cnt_q + 1'b1;
            end
        end else begin
            if (h_cnt_q != '1) begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
            if (video_en_i && (a_cnt_q != '1)) begin
                a_cnt_d = a_cnt_q + 1'b1;
            end
        end
        v_cnt_d  = v_cnt_line;
        al_cnt_d = al_cnt_line;
        if (v_edge) begin
            v_viol   = (v_cnt_line != V_FRAME) || (al_cnt_line != AL_FRAME);
            v_cnt_d  = '0;
            al_cnt_d = '0;
        end
    end

    always_comb begin
        x_cnt_d   = x_cnt_q;
        y_cnt_d   = y_cnt_q;
        pix_cnt_d = pix_cnt_q;
        if (video_en_i) begin
            if (x_cnt_q != X_LAST) begin
                x_cnt_d = x_cnt_q + 1'b1;
            end
            if (pix_cnt_q != P_LAST) begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
        end else if (ven_q) begin
            x_cnt_d = '0;
            if (y_cnt_q != Y_LAST) begin
                y_cnt_d = y_cnt_q + 1'b1;
            end
        end
        if (v_edge) begin
            y_cnt_d   = '0;
            pix_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= SEARCH;
            clean_q <= '0;
        end else begin
            state_q <= state_d;
            clean_q <= clean_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clean_d = clean_q;
        viol    = 1'b0;
        case (state_q)
            SEARCH: begin
                if (v_edge) begin
                    state_d = ALIGN;
                    clean_d = '0;
                end
            end
            ALIGN: begin
                viol = h_viol || v_viol;
                if (viol) begin
                    clean_d = '0;
                end else if (v_edge) begin
                    if (clean_q == CLEAN_LAST) begin
                        state_d = LOCKED;
                        clean_d = '0;
                    end else begin
                        clean_d = clean_q + 1'b1;
                    end
                end
            end
            LOCKED: begin
                viol = h_viol || v_viol;
                if (viol) begin
                    state_d = SEARCH;
                end
            end
            default: begin
                state_d = SEARCH;
                clean_d = '0;
            end
        endcase
    end

    always_comb begin
        locked_o      = (state_q == LOCKED);
        pixel_valid_o = valid_q;
        x_o           = x_q;
        y_o           = y_q;
        pixel_o       = pix_q;
        frame_start_o = fs_q;
        error_o       = err_q;
    end

    // Validity follows the post-update state so it never outlives locked_o.
    always_comb begin
        valid_d = video_en_i && (state_d == LOCKED);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            ven_q     <= 1'b0;
            h_cnt_q   <= '0;
            a_cnt_q   <= '0;
            v_cnt_q   <= '0;
            al_cnt_q  <= '0;
            x_cnt_q   <= '0;
            y_cnt_q   <= '0;
            pix_cnt_q <= '0;
            valid_q   <= 1'b0;
            fs_q      <= 1'b0;
            err_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            pix_q     <= '0;
        end else begin
            hs_q      <= hsync_i;
            vs_q      <= vsync_i;
            ven_q     <= video_en_i;
            h_cnt_q   <= h_cnt_d;
            a_cnt_q   <= a_cnt_d;
            v_cnt_q   <= v_cnt_d;
            al_cnt_q  <= al_cnt_d;
            x_cnt_q   <= x_cnt_d;
            y_cnt_q   <= y_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            valid_q   <= valid_d;
            fs_q      <= valid_d && (pix_cnt_q == '0);
            err_q     <= viol;
            if (valid_d) begin
                x_q   <= x_cnt_q;
                y_q   <= y_cnt_q;
                pix_q <= pix_cnt_q;
            end
        end
    end

endmodule
